// File: rtl/fifo_sram_pkg.sv
// Shared types and helpers for the FIFO-to-SRAM loader.
package fifo_sram_pkg;

    // Loader sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } ldr_state_e;

    // True on the cycle a level signal goes from low to high.
    function automatic logic rise_edge(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read, occupancy and a
// sticky overflow flag. Pointers carry an extra wrap bit so full and empty
// are told apart without a separate counter.
module sync_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [DW-1:0]              push_data_i,
    input  logic                       pop_i,
    output logic [DW-1:0]              pop_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       overflow_o
);

    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW:0]   wr_ptr_q, wr_ptr_d;
    logic [PW:0]   rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;
    logic          do_push;
    logic          do_pop;

    assign full_o     = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign level_o    = wr_ptr_q - rd_ptr_q;
    assign overflow_o = overflow_q;
    assign pop_data_o = mem_q[rd_ptr_q[PW-1:0]];

    // A push into a full FIFO is dropped, even if a pop happens alongside.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointer and overflow next-state.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_i && full_o) begin
            overflow_d = 1'b1;
        end
    end

    // Pointer and overflow registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; contents need no reset since the pointers gate them.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/fifo_sram_loader.sv
// Drains a host-fed FIFO into consecutive SRAM words on request, and lets
// the micro side read or write the same single-port SRAM when the loader
// is not in control.
module fifo_sram_loader
    import fifo_sram_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 13,
    parameter int DEPTH   = 16,
    parameter int WR_EDGE = 1
) (
    input  logic                    ldr_clk_i,
    input  logic                    ldr_rst_i,
    input  logic                    fifo_writeflag_i,
    input  logic [DW-1:0]           fifo_writedata_i,
    output logic                    fifo_fullflag_o,
    output logic [$clog2(DEPTH):0]  fifo_level_o,
    output logic                    fifo_overflow_o,
    input  logic                    micro_control_i,
    input  logic                    write_mem_init_i,
    input  logic [AW-1:0]           base_addr_i,
    output logic                    busy_o,
    output logic                    flag_writefinish_o,
    output logic [AW:0]             words_written_o,
    input  logic [AW-1:0]           micro_sram_address_i,
    input  logic [DW-1:0]           micro_sram_datain_i,
    input  logic                    micro_sram_cs_i,
    input  logic                    micro_sram_we_i,
    output logic [DW-1:0]           sram_data_o,
    output logic                    micro_valid_o,
    output logic                    mem_en_o,
    output logic                    mem_we_o,
    output logic [AW-1:0]           mem_addr_o,
    output logic [DW-1:0]           mem_wdata_o,
    input  logic [DW-1:0]           mem_rdata_i
);

    // Edge-detect history.
    logic flag_q;
    logic init_q;
    logic cs_q;

    // FSM and datapath state.
    ldr_state_e    state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW:0]   count_q, count_d;
    logic          busy_q, busy_d;
    logic          fin_q, fin_d;
    logic [AW:0]   words_q, words_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          rd_pend_q, rd_pend_d;
    logic          rd_cap_q, rd_cap_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          valid_q, valid_d;

    // FIFO hookup.
    logic          push_req;
    logic          pop;
    logic [DW-1:0] fifo_head;
    logic          fifo_empty;

    logic load_start;
    logic cs_rise;
    logic micro_pending;

    assign push_req      = (WR_EDGE != 0) ? rise_edge(fifo_writeflag_i, flag_q)
                                          : fifo_writeflag_i;
    assign load_start    = rise_edge(write_mem_init_i, init_q) & micro_control_i;
    assign cs_rise       = rise_edge(micro_sram_cs_i, cs_q);
    // An access is outstanding from launch until its read data is captured.
    assign micro_pending = mem_en_q | rd_pend_q | rd_cap_q;

    sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (ldr_clk_i),
        .rst_i       (ldr_rst_i),
        .push_i      (push_req),
        .push_data_i (fifo_writedata_i),
        .pop_i       (pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_fullflag_o),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level_o),
        .overflow_o  (fifo_overflow_o)
    );

    // Loader FSM, micro arbitration and SRAM port next-state.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        count_d     = count_q;
        busy_d      = busy_q;
        fin_d       = fin_q;
        words_d     = words_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_pend_d   = 1'b0;
        rd_cap_d    = rd_pend_q;
        rdata_d     = rdata_q;
        valid_d     = 1'b0;
        pop         = 1'b0;

        // SRAM read data is valid the cycle after the read was issued.
        if (rd_cap_q) begin
            rdata_d = mem_rdata_i;
            valid_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d = ST_DRAIN;
                    base_d  = base_addr_i;
                    count_d = '0;
                    busy_d  = 1'b1;
                    fin_d   = 1'b0;
                end else if (!micro_control_i && cs_rise && !micro_pending) begin
                    mem_en_d    = 1'b1;
                    mem_we_d    = ~micro_sram_we_i;
                    mem_addr_d  = micro_sram_address_i;
                    mem_wdata_d = micro_sram_datain_i;
                    rd_pend_d   = micro_sram_we_i;
                end
            end
            ST_DRAIN: begin
                if (!micro_control_i) begin
                    // Abort: the write already on the bus finishes by itself.
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (!fifo_empty) begin
                    pop         = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = base_q + count_q[AW-1:0];
                    mem_wdata_d = fifo_head;
                    count_d     = count_q + 1'b1;
                end else begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    fin_d   = 1'b1;
                    words_d = count_q;
                end
            end
            ST_DONE: begin
                if (!write_mem_init_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register for the FSM, SRAM port and edge-detect history.
    always_ff @(posedge ldr_clk_i or posedge ldr_rst_i) begin
        if (ldr_rst_i) begin
            flag_q      <= 1'b0;
            init_q      <= 1'b0;
            cs_q        <= 1'b0;
            state_q     <= ST_IDLE;
            base_q      <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            fin_q       <= 1'b0;
            words_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_pend_q   <= 1'b0;
            rd_cap_q    <= 1'b0;
            rdata_q     <= '0;
            valid_q     <= 1'b0;
        end else begin
            flag_q      <= fifo_writeflag_i;
            init_q      <= write_mem_init_i;
            cs_q        <= micro_sram_cs_i;
            state_q     <= state_d;
            base_q      <= base_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            fin_q       <= fin_d;
            words_q     <= words_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_pend_q   <= rd_pend_d;
            rd_cap_q    <= rd_cap_d;
            rdata_q     <= rdata_d;
            valid_q     <= valid_d;
        end
    end

    assign busy_o             = busy_q;
    assign flag_writefinish_o = fin_q;
    assign words_written_o    = words_q;
    assign sram_data_o        = rdata_q;
    assign micro_valid_o      = valid_q;
    assign mem_en_o           = mem_en_q;
    assign mem_we_o           = mem_we_q;
    assign mem_addr_o         = mem_addr_q;
    assign mem_wdata_o        = mem_wdata_q;

endmodule

// File: tb/tb_fifo_sram_loader.sv
// Directed bench for fifo_sram_loader with a behavioural single-port SRAM.
module tb_fifo_sram_loader;

    logic        clk;
    logic        rst;
    logic        wflag;
    logic [31:0] wdata;
    logic        full;
    logic [4:0]  level;
    logic        ovf;
    logic        mctl;
    logic        init;
    logic [12:0] base;
    logic        busy;
    logic        fin;
    logic [13:0] words;
    logic [12:0] maddr;
    logic [31:0] mdin;
    logic        cs;
    logic        we;
    logic [31:0] rd_out;
    logic        mvalid;
    logic        mem_en;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] sram [8192];

    int n_cmp;
    int n_fail;

    fifo_sram_loader #(
        .DW(32), .AW(13), .DEPTH(16), .WR_EDGE(1)
    ) dut (
        .ldr_clk_i            (clk),
        .ldr_rst_i            (rst),
        .fifo_writeflag_i     (wflag),
        .fifo_writedata_i     (wdata),
        .fifo_fullflag_o      (full),
        .fifo_level_o         (level),
        .fifo_overflow_o      (ovf),
        .micro_control_i      (mctl),
        .write_mem_init_i     (init),
        .base_addr_i          (base),
        .busy_o               (busy),
        .flag_writefinish_o   (fin),
        .words_written_o      (words),
        .micro_sram_address_i (maddr),
        .micro_sram_datain_i  (mdin),
        .micro_sram_cs_i      (cs),
        .micro_sram_we_i      (we),
        .sram_data_o          (rd_out),
        .micro_valid_o        (mvalid),
        .mem_en_o             (mem_en),
        .mem_we_o             (mem_we),
        .mem_addr_o           (mem_addr),
        .mem_wdata_o          (mem_wdata),
        .mem_rdata_i          (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port SRAM with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata <= sram[mem_addr];
        end
    end

    task automatic push_word(input logic [31:0] d, input int hold);
        @(negedge clk);
        wflag = 1'b1;
        wdata = d;
        repeat (hold) @(negedge clk);
        wflag = 1'b0;
        $display("push %h", d);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({full, level, ovf, busy, fin, words, rd_out, mvalid,
             mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got nonzero level=%0d busy=%b mem_en=%b, expected all zero",
                     level, busy, mem_en);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_push_edge();
        push_word(32'hADAD0011, 2);
        push_word(32'h000A0201, 2);
        push_word(32'h00000001, 2);
        push_word(32'hABCD1234, 2);
        @(negedge clk);
        n_cmp++;
        if (level !== 5'd4) begin
            n_fail++; $display("FAIL push_level: got %0d expected 4", level);
        end
        n_cmp++;
        if ({ovf, full} !== 2'b00) begin
            n_fail++; $display("FAIL push_flags: got ovf=%b full=%b expected 0 0", ovf, full);
        end
    endtask

    task automatic test_load();
        mctl = 1'b1;
        base = 13'h0000;
        init = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy, fin} !== 2'b10) begin
            n_fail++; $display("FAIL load_busy: got busy=%b fin=%b expected 1 0", busy, fin);
        end
        @(negedge clk);
        n_cmp++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 13'h0000, 32'hADAD0011}) begin
            n_fail++;
            $display("FAIL load_first_write: got en=%b we=%b a=%h d=%h expected 1 1 0000 adad0011",
                     mem_en, mem_we, mem_addr, mem_wdata);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, fin} !== 2'b10) begin
            n_fail++; $display("FAIL load_not_done_yet: got busy=%b fin=%b expected 1 0", busy, fin);
        end
        @(negedge clk);
        n_cmp++;
        if ({busy, fin, words, level} !== {1'b0, 1'b1, 14'd4, 5'd0}) begin
            n_fail++;
            $display("FAIL load_done: got busy=%b fin=%b words=%0d level=%0d expected 0 1 4 0",
                     busy, fin, words, level);
        end
        n_cmp++;
        if ({sram[0], sram[1], sram[2], sram[3]} !==
            {32'hADAD0011, 32'h000A0201, 32'h00000001, 32'hABCD1234}) begin
            n_fail++;
            $display("FAIL load_sram: got %h %h %h %h expected adad0011 000a0201 00000001 abcd1234",
                     sram[0], sram[1], sram[2], sram[3]);
        end
        init = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (fin !== 1'b1) begin
            n_fail++; $display("FAIL load_fin_hold: got %b expected 1", fin);
        end
        $display("test_load done");
    endtask

    task automatic test_micro();
        logic [31:0] exp_rd [3];
        exp_rd[0] = 32'hADAD0011;
        exp_rd[1] = 32'h000A0201;
        exp_rd[2] = 32'h00000001;
        mctl = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            cs = 1'b1; we = 1'b1; maddr = 13'(i);
            @(negedge clk);
            n_cmp++;
            if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 13'(i)}) begin
                n_fail++;
                $display("FAIL micro_rd_issue[%0d]: got en=%b we=%b a=%h expected 1 0 %h",
                         i, mem_en, mem_we, mem_addr, 13'(i));
            end
            @(negedge clk);
            n_cmp++;
            if (mvalid !== 1'b0) begin
                n_fail++; $display("FAIL micro_valid_early[%0d]: got 1 expected 0", i);
            end
            @(negedge clk);
            n_cmp++;
            if ({mvalid, rd_out} !== {1'b1, exp_rd[i]}) begin
                n_fail++;
                $display("FAIL micro_rd_data[%0d]: got v=%b d=%h expected 1 %h",
                         i, mvalid, rd_out, exp_rd[i]);
            end
            cs = 1'b0;
            @(negedge clk);
            n_cmp++;
            if ({mvalid, rd_out} !== {1'b0, exp_rd[i]}) begin
                n_fail++;
                $display("FAIL micro_rd_hold[%0d]: got v=%b d=%h expected 0 %h",
                         i, mvalid, rd_out, exp_rd[i]);
            end
            $display("micro read a=%0d d=%h", i, rd_out);
        end
        // One micro write, then check the SRAM saw it.
        cs = 1'b1; we = 1'b0; maddr = 13'h0005; mdin = 32'h5555AAAA;
        @(negedge clk);
        n_cmp++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 13'h0005, 32'h5555AAAA}) begin
            n_fail++;
            $display("FAIL micro_wr_issue: got en=%b we=%b a=%h d=%h expected 1 1 0005 5555aaaa",
                     mem_en, mem_we, mem_addr, mem_wdata);
        end
        cs = 1'b0; we = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (sram[5] !== 32'h5555AAAA) begin
            n_fail++; $display("FAIL micro_wr_sram: got %h expected 5555aaaa", sram[5]);
        end
        $display("micro write a=5 d=5555aaaa");
    endtask

    task automatic test_overflow_wrap();
        for (int i = 0; i < 17; i++) begin
            push_word(32'h10000000 + 32'(i), 1);
        end
        @(negedge clk);
        n_cmp++;
        if ({level, full, ovf} !== {5'd16, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL overflow_flags: got level=%0d full=%b ovf=%b expected 16 1 1", level, full, ovf);
        end
        mctl = 1'b1;
        base = 13'h1FFE;
        init = 1'b1;
        repeat (18) @(negedge clk);
        n_cmp++;
        if ({fin, words, level, full} !== {1'b1, 14'd16, 5'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_done: got fin=%b words=%0d level=%0d full=%b expected 1 16 0 0",
                     fin, words, level, full);
        end
        n_cmp++;
        if ({sram[8190], sram[8191], sram[0], sram[13]} !==
            {32'h10000000, 32'h10000001, 32'h10000002, 32'h1000000F}) begin
            n_fail++;
            $display("FAIL wrap_sram: got %h %h %h %h expected 10000000 10000001 10000002 1000000f",
                     sram[8190], sram[8191], sram[0], sram[13]);
        end
        n_cmp++;
        if (ovf !== 1'b1) begin
            n_fail++; $display("FAIL overflow_sticky: got %b expected 1", ovf);
        end
        init = 1'b0;
        @(negedge clk);
        $display("test_overflow_wrap done");
    endtask

    task automatic test_empty_load();
        base = 13'h0040;
        init = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy, fin} !== 2'b10) begin
            n_fail++; $display("FAIL empty_busy: got busy=%b fin=%b expected 1 0", busy, fin);
        end
        @(negedge clk);
        n_cmp++;
        if ({busy, fin, words, mem_en} !== {1'b0, 1'b1, 14'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL empty_done: got busy=%b fin=%b words=%0d en=%b expected 0 1 0 0",
                     busy, fin, words, mem_en);
        end
        init = 1'b0;
        @(negedge clk);
        $display("test_empty_load done");
    endtask

    task automatic test_abort_and_reset();
        for (int i = 0; i < 4; i++) begin
            push_word(32'h000000A0 + 32'(i), 1);
        end
        @(negedge clk);
        base = 13'h0100;
        init = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        mctl = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, fin, level} !== {1'b0, 1'b0, 5'd2}) begin
            n_fail++;
            $display("FAIL abort_state: got busy=%b fin=%b level=%0d expected 0 0 2", busy, fin, level);
        end
        n_cmp++;
        if ({sram[256], sram[257]} !== {32'h000000A0, 32'h000000A1}) begin
            n_fail++;
            $display("FAIL abort_sram: got %h %h expected 000000a0 000000a1", sram[256], sram[257]);
        end
        init = 1'b0;
        @(negedge clk);
        // Restart and reset in the middle of the load.
        mctl = 1'b1;
        init = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy, mem_en} !== 2'b11) begin
            n_fail++; $display("FAIL reload_active: got busy=%b en=%b expected 1 1", busy, mem_en);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({full, level, ovf, busy, fin, words, rd_out, mvalid,
             mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_midload: got level=%0d busy=%b en=%b ovf=%b words=%0d expected all zero",
                     level, busy, mem_en, ovf, words);
        end
        @(negedge clk);
        rst  = 1'b0;
        init = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({level, busy} !== {5'd0, 1'b0}) begin
            n_fail++; $display("FAIL post_reset: got level=%0d busy=%b expected 0 0", level, busy);
        end
        $display("test_abort_and_reset done");
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        wflag  = 1'b0;
        wdata  = '0;
        mctl   = 1'b0;
        init   = 1'b0;
        base   = '0;
        maddr  = '0;
        mdin   = '0;
        cs     = 1'b0;
        we     = 1'b1;
        mem_rdata = '0;
        test_reset();
        test_push_edge();
        test_load();
        test_micro();
        test_overflow_wrap();
        test_empty_load();
        test_abort_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
